mult_seq_ctrl: RTL and testbench

MULT_SEQ_CTRL -- requirements
Module: mult_seq_ctrl

---
 rtl/mult_seq_ctrl.sv | 118 +++++++++++
 tb/tb_mult_seq_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_seq_ctrl.sv
// Sequencer for a digit-serial long-operand multiply: one multiplier digit per MUL_LAT+1 cycles.
// Define MULT_SEQ_ABORT_EN to add the abort input that cancels an operation in flight.
module mult_seq_ctrl #(
  parameter int unsigned NUM_DIGITS = 55,
  parameter int unsigned MUL_LAT    = 4,
  localparam int unsigned KW        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
`ifdef MULT_SEQ_ABORT_EN
  input  logic          abort,
`endif
  output logic          busy,
  output logic          mul_en,
  output logic [KW-1:0] b_idx,
  output logic          acc_clr,
  output logic          acc_we,
  output logic          done
);

  localparam int unsigned CW = 4;
  localparam logic [KW-1:0] KLast = KW'(NUM_DIGITS - 1);
  localparam logic [CW-1:0] CLast = CW'(MUL_LAT - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StFin} state_e;

  state_e        state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          mul_en_q, mul_en_d;
  logic          acc_clr_q, acc_clr_d;
  logic          acc_we_q, acc_we_d;
  logic          done_q, done_d;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StIssue;
          k_d     = '0;
        end
      end
      StIssue: begin
        state_d = StWait;
        cnt_d   = '0;
      end
      StWait: begin
        if (cnt_q == CLast) begin
          if (k_q == KLast) begin
            state_d = StFin;
          end else begin
            state_d = StIssue;
            k_d     = k_q + KW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StFin: begin
        state_d = StIdle;
        k_d     = '0;
      end
      default: state_d = StIdle;
    endcase

`ifdef MULT_SEQ_ABORT_EN
    // Abort only cancels work in flight; in IDLE a simultaneous start still launches.
    if (abort && (state_q != StIdle)) begin
      state_d = StIdle;
      k_d     = '0;
      cnt_d   = '0;
    end
`endif

    // Outputs are decoded from the next state so they register alongside it.
    busy_d    = (state_d != StIdle);
    mul_en_d  = (state_d == StIssue);
    acc_clr_d = (state_d == StIssue) && (k_d == '0);
    acc_we_d  = (state_d == StWait) && (cnt_d == CLast);
    done_d    = (state_d == StFin);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      k_q       <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      mul_en_q  <= 1'b0;
      acc_clr_q <= 1'b0;
      acc_we_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      mul_en_q  <= mul_en_d;
      acc_clr_q <= acc_clr_d;
      acc_we_q  <= acc_we_d;
      done_q    <= done_d;
    end
  end

  assign busy    = busy_q;
  assign mul_en  = mul_en_q;
  assign b_idx   = k_q;
  assign acc_clr = acc_clr_q;
  assign acc_we  = acc_we_q;
  assign done    = done_q;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Bench for mult_seq_ctrl: a timeline model checked every cycle plus directed literal timings.
// Two instances: NUM_DIGITS=4/MUL_LAT=3 and the NUM_DIGITS=1/MUL_LAT=1 corner.
module tb_mult_seq_ctrl;

  localparam int N = 4;
  localparam int L = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       start1 = 1'b0;
  logic       abort = 1'b0;
  logic       busy0, mul_en0, acc_clr0, acc_we0, done0;
  logic [1:0] b_idx0;
  logic       busy1, mul_en1, acc_clr1, acc_we1, done1;
  logic [0:0] b_idx1;

  int checks = 0;
  int fails = 0;
  int t0 = 0;
  int t1 = 0;
  int nm[2];
  int nw[2];
  int q_mul[$], q_we[$], q_done[$], q_clr[$], q_bi[$], q_busy[$];
  int e[$];

  always #5 clk = ~clk;

  mult_seq_ctrl #(.NUM_DIGITS(N), .MUL_LAT(L)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start),
`ifdef MULT_SEQ_ABORT_EN
    .abort(abort),
`endif
    .busy(busy0), .mul_en(mul_en0), .b_idx(b_idx0), .acc_clr(acc_clr0),
    .acc_we(acc_we0), .done(done0)
  );

  mult_seq_ctrl #(.NUM_DIGITS(1), .MUL_LAT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1),
`ifdef MULT_SEQ_ABORT_EN
    .abort(abort),
`endif
    .busy(busy1), .mul_en(mul_en1), .b_idx(b_idx1), .acc_clr(acc_clr1),
    .acc_we(acc_we1), .done(done1)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Model: t = cycles since the accepting edge (0 = idle); an op spans t = 1 .. n*(l+1)+1.
  function automatic int next_t(input int t, input logic s, input logic ab, input int n,
                                input int l);
    if (t == 0) return s ? 1 : 0;
    if (ab) return 0;
    if (t == n * (l + 1) + 1) return 0;
    return t + 1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t0 <= 0;
      t1 <= 0;
    end else begin
      t0 <= next_t(t0, start, abort, N, L);
      t1 <= next_t(t1, start1, abort, 1, 1);
    end
  end

  task automatic check_dut(input int id, input int t, input int n, input int l, input logic b,
                           input logic m, input logic c, input logic w, input logic d,
                           input int bi);
    int  tot;
    bit  act;
    int  r;
    string p;
    tot = n * (l + 1);
    act = (t >= 1) && (t <= tot);
    r   = act ? (t - 1) % (l + 1) : 0;
    p   = (id == 0) ? "dut0" : "dut1";
    chk({p, ".busy"}, int'(b), int'(t != 0));
    chk({p, ".mul_en"}, int'(m), int'(act && r == 0));
    chk({p, ".acc_clr"}, int'(c), int'(t == 1));
    chk({p, ".acc_we"}, int'(w), int'(act && r == l));
    chk({p, ".done"}, int'(d), int'(t == tot + 1));
    if (act) chk({p, ".b_idx"}, bi, (t - 1) / (l + 1));
    chk({p, ".mul_en_and_acc_we"}, int'(m && w), 0);
    chk({p, ".b_idx_range"}, int'(bi < n), 1);
    if (m && c) begin
      nm[id] = 0;
      nw[id] = 0;
    end
    nm[id] += int'(m);
    nw[id] += int'(w);
    if (d) begin
      chk({p, ".acc_we_count_vs_mul_en"}, nw[id], nm[id]);
      chk({p, ".mul_en_count"}, nm[id], n);
    end
  endtask

  always @(negedge clk) begin
    check_dut(0, t0, N, L, busy0, mul_en0, acc_clr0, acc_we0, done0, int'(b_idx0));
    check_dut(1, t1, 1, 1, busy1, mul_en1, acc_clr1, acc_we1, done1, int'(b_idx1));
  end

  // Called at the negedge of cycle 0 with the start input already set.
  task automatic collect(input int id, input int ncyc, input bit hold);
    q_mul = {}; q_we = {}; q_done = {}; q_clr = {}; q_bi = {}; q_busy = {};
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      if (!hold) begin
        start  = 1'b0;
        start1 = 1'b0;
      end
      if (id == 0) begin
        if (mul_en0) begin q_mul.push_back(c); q_bi.push_back(int'(b_idx0)); end
        if (acc_we0) q_we.push_back(c);
        if (done0) q_done.push_back(c);
        if (acc_clr0) q_clr.push_back(c);
        if (busy0) q_busy.push_back(c);
      end else begin
        if (mul_en1) begin q_mul.push_back(c); q_bi.push_back(int'(b_idx1)); end
        if (acc_we1) q_we.push_back(c);
        if (done1) q_done.push_back(c);
        if (acc_clr1) q_clr.push_back(c);
        if (busy1) q_busy.push_back(c);
      end
    end
  endtask

  task automatic chk_q(input string name, input int got[$], input int exp[$]);
    chk({name, ".count"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++) chk(name, got[i], exp[i]);
  endtask

  task automatic chk_busy_span(input string name, input int first, input int last);
    chk({name, ".busy_cycles"}, q_busy.size(), last - first + 1);
    if (q_busy.size() > 0) begin
      chk({name, ".busy_first"}, q_busy[0], first);
      chk({name, ".busy_last"}, q_busy[q_busy.size() - 1], last);
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, ".busy0"}, int'(busy0), 0);
    chk({name, ".mul_en0"}, int'(mul_en0), 0);
    chk({name, ".acc_clr0"}, int'(acc_clr0), 0);
    chk({name, ".acc_we0"}, int'(acc_we0), 0);
    chk({name, ".done0"}, int'(done0), 0);
    chk({name, ".b_idx0"}, int'(b_idx0), 0);
    chk({name, ".busy1"}, int'(busy1), 0);
    chk({name, ".done1"}, int'(done1), 0);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1 chk_all_zero("reset");
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single run.
    start = 1'b1;
    collect(0, 19, 1'b0);
    e = {1, 5, 9, 13};   chk_q("run1.mul_en", q_mul, e);
    e = {0, 1, 2, 3};    chk_q("run1.b_idx", q_bi, e);
    e = {1};             chk_q("run1.acc_clr", q_clr, e);
    e = {4, 8, 12, 16};  chk_q("run1.acc_we", q_we, e);
    e = {17};            chk_q("run1.done", q_done, e);
    chk_busy_span("run1", 1, 17);

    // Start held high: second run only after a one-cycle idle gap.
    start = 1'b1;
    collect(0, 36, 1'b1);
    start = 1'b0;
    e = {1, 5, 9, 13, 19, 23, 27, 31}; chk_q("hold.mul_en", q_mul, e);
    e = {17, 35};                      chk_q("hold.done", q_done, e);
    e = {1, 19};                       chk_q("hold.acc_clr", q_clr, e);
    repeat (3) @(negedge clk);

    // Reset mid-operation, then restart from digit 0.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    chk("rst.busy_before", int'(busy0), 1);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("rst.async");
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("rst.restart_mul_en", int'(mul_en0), 1);
    chk("rst.restart_b_idx", int'(b_idx0), 0);
    chk("rst.restart_acc_clr", int'(acc_clr0), 1);
    repeat (20) @(negedge clk);

    // Single-digit, single-latency corner.
    start1 = 1'b1;
    collect(1, 5, 1'b0);
    e = {1}; chk_q("n1.mul_en", q_mul, e);
    e = {1}; chk_q("n1.acc_clr", q_clr, e);
    e = {2}; chk_q("n1.acc_we", q_we, e);
    e = {3}; chk_q("n1.done", q_done, e);
    chk_busy_span("n1", 1, 3);

`ifdef MULT_SEQ_ABORT_EN
    begin
      int nb, nwe, nd;
      nb = 0; nwe = 0; nd = 0;
      @(negedge clk);
      start = 1'b1;
      for (int c = 1; c <= 20; c++) begin
        @(negedge clk);
        start = 1'b0;
        abort = (c == 6);
        if (c >= 7) begin
          nb  += int'(busy0);
          nwe += int'(acc_we0);
          nd  += int'(done0);
        end
      end
      chk("abort.busy_after", nb, 0);
      chk("abort.acc_we_after", nwe, 0);
      chk("abort.done_after", nd, 0);
      abort = 1'b1;
      repeat (2) @(negedge clk);
      chk("abort.idle_no_effect", int'(busy0), 0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      chk("abort.start_wins_mul_en", int'(mul_en0), 1);
      chk("abort.start_wins_acc_clr", int'(acc_clr0), 1);
      repeat (20) @(negedge clk);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
